// File: rtl/fbuf_pkg.sv
// fbuf_pkg: shared types and default widths for the framebuffer write arbiter.
// Provides the arbiter state enum and default address/data bus widths.
package fbuf_pkg;

  localparam int FBUF_ADDR_W_DEF = 19;
  localparam int FBUF_DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } fbuf_arb_state_t;

endpackage

// File: rtl/fbuf_write_arbiter_if.sv
// fbuf_write_arbiter_if: one writer channel into the framebuffer arbiter.
// Ports: valid/addr/data from the writer, ready back from the arbiter.
interface fbuf_write_arbiter_if
  import fbuf_pkg::*;
#(
  parameter int ADDR_WIDTH = FBUF_ADDR_W_DEF,
  parameter int DATA_WIDTH = FBUF_DATA_W_DEF
);

  logic                  valid;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;

  modport master (
    output valid,
    output addr,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  addr,
    input  data,
    output ready
  );

endinterface

// File: rtl/fbuf_write_port_reg.sv
// fbuf_write_port_reg: registered BRAM write port (en, wrea, addr, data).
// Ports: clk, rst (sync, active-high), wr/wr_addr/wr_data in; fbuf_* out.
module fbuf_write_port_reg
  import fbuf_pkg::*;
#(
  parameter int ADDR_WIDTH = FBUF_ADDR_W_DEF,
  parameter int DATA_WIDTH = FBUF_DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  fbuf_en_wr,
  output logic                  fbuf_wrea,
  output logic [ADDR_WIDTH-1:0] fbuf_addr,
  output logic [DATA_WIDTH-1:0] fbuf_data
);

  // Strobes last exactly one cycle per beat; addr/data
  // keep their last value between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      fbuf_en_wr <= 1'b0;
      fbuf_wrea  <= 1'b0;
      fbuf_addr  <= '0;
      fbuf_data  <= '0;
    end else begin
      fbuf_en_wr <= wr;
      fbuf_wrea  <= wr;
      if (wr) begin
        fbuf_addr <= wr_addr;
        fbuf_data <= wr_data;
      end
    end
  end

endmodule

// File: rtl/fbuf_write_arbiter.sv
// fbuf_write_arbiter: round-robin arbiter of two writers onto one BRAM port.
// Ports: clk, rst, ch0/ch1 (slave channels), sel, busy, fbuf_* write port.
// FBUF_ARB_BURST_LIMIT_EN: rotate grant after MAX_BURST beats if other waits.
module fbuf_write_arbiter
  import fbuf_pkg::*;
#(
  parameter int FBUF_ADDR_WIDTH = FBUF_ADDR_W_DEF,
  parameter int FBUF_DATA_WIDTH = FBUF_DATA_W_DEF,
  parameter int MAX_BURST       = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  fbuf_write_arbiter_if.slave        ch0,
  fbuf_write_arbiter_if.slave        ch1,
  output logic                       sel,
  output logic                       busy,
  output logic                       fbuf_en_wr,
  output logic                       fbuf_wrea,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0] fbuf_data
);

  if (MAX_BURST < 2) begin : g_bad_burst
    $error("MAX_BURST must be at least 2");
  end

  fbuf_arb_state_t state;
  fbuf_arb_state_t state_nx;

  logic last;
  logic last_nx;
  logic sel_nx;
  logic xfer0;
  logic xfer1;
  logic xfer;

  logic [FBUF_ADDR_WIDTH-1:0] wr_addr;
  logic [FBUF_DATA_WIDTH-1:0] wr_data;

`ifdef FBUF_ARB_BURST_LIMIT_EN
  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] beat_cnt_nx;
  logic          at_limit;

  assign at_limit = (beat_cnt == LAST_BEAT);
`endif

  // Ready depends on state only, so a writer may
  // hold valid without a combinational loop.
  assign ch0.ready = (state == GRANT0);
  assign ch1.ready = (state == GRANT1);

  assign xfer0 = ch0.valid && ch0.ready;
  assign xfer1 = ch1.valid && ch1.ready;
  assign xfer  = xfer0 || xfer1;

  assign wr_addr = xfer1 ? ch1.addr : ch0.addr;
  assign wr_data = xfer1 ? ch1.data : ch0.data;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      sel   <= 1'b0;
    end else begin
      state <= state_nx;
      last  <= last_nx;
      sel   <= sel_nx;
    end
  end

`ifdef FBUF_ARB_BURST_LIMIT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else begin
      beat_cnt <= beat_cnt_nx;
    end
  end
`endif

  always_comb begin
    state_nx = state;
`ifdef FBUF_ARB_BURST_LIMIT_EN
    beat_cnt_nx = beat_cnt;
`endif
    case (state)
      IDLE: begin
        unique case (1'b1)
          !ch0.valid && !ch1.valid: state_nx = IDLE;
          ch0.valid && !ch1.valid:  state_nx = GRANT0;
          !ch0.valid && ch1.valid:  state_nx = GRANT1;
          // Tie goes to whoever was not served last.
          ch0.valid && ch1.valid:
            state_nx = last ? GRANT0 : GRANT1;
        endcase
      end
      GRANT0: begin
        if (!ch0.valid) begin
          state_nx = ch1.valid ? GRANT1 : IDLE;
`ifdef FBUF_ARB_BURST_LIMIT_EN
          beat_cnt_nx = '0;
        end else if (at_limit) begin
          beat_cnt_nx = '0;
          if (ch1.valid) state_nx = GRANT1;
        end else begin
          beat_cnt_nx = beat_cnt + CW'(1);
`endif
        end
      end
      GRANT1: begin
        if (!ch1.valid) begin
          state_nx = ch0.valid ? GRANT0 : IDLE;
`ifdef FBUF_ARB_BURST_LIMIT_EN
          beat_cnt_nx = '0;
        end else if (at_limit) begin
          beat_cnt_nx = '0;
          if (ch0.valid) state_nx = GRANT0;
        end else begin
          beat_cnt_nx = beat_cnt + CW'(1);
`endif
        end
      end
      default: begin
        state_nx = IDLE;
`ifdef FBUF_ARB_BURST_LIMIT_EN
        beat_cnt_nx = '0;
`endif
      end
    endcase
  end

  // Owner pointer and sel track the grant being
  // entered; both hold through IDLE.
  always_comb begin
    last_nx = last;
    sel_nx  = sel;
    unique case (1'b1)
      state_nx == GRANT0: begin
        last_nx = 1'b0;
        sel_nx  = 1'b0;
      end
      state_nx == GRANT1: begin
        last_nx = 1'b1;
        sel_nx  = 1'b1;
      end
      default: ;
    endcase
  end

  fbuf_write_port_reg #(
    .ADDR_WIDTH (FBUF_ADDR_WIDTH),
    .DATA_WIDTH (FBUF_DATA_WIDTH)
  ) u_port (
    .clk        (clk),
    .rst        (rst),
    .wr         (xfer),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .fbuf_en_wr (fbuf_en_wr),
    .fbuf_wrea  (fbuf_wrea),
    .fbuf_addr  (fbuf_addr),
    .fbuf_data  (fbuf_data)
  );

endmodule

// File: tb/tb_fbuf_write_arbiter.sv
// tb_fbuf_write_arbiter: directed scoreboard bench for fbuf_write_arbiter.
// Expected writes (addr, data, cycle) are queued; a negedge monitor checks.
module tb_fbuf_write_arbiter;

  localparam int AW = 19;
  localparam int DW = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic busy;
  logic fbuf_en_wr;
  logic fbuf_wrea;
  logic [AW-1:0] fbuf_addr;
  logic [DW-1:0] fbuf_data;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   t0;
  exp_t exp_q[$];
  exp_t mon_e;

  fbuf_write_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) c0 ();
  fbuf_write_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) c1 ();

  fbuf_write_arbiter #(
    .FBUF_ADDR_WIDTH (AW),
    .FBUF_DATA_WIDTH (DW),
    .MAX_BURST       (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ch0        (c0),
    .ch1        (c1),
    .sel        (sel),
    .busy       (busy),
    .fbuf_en_wr (fbuf_en_wr),
    .fbuf_wrea  (fbuf_wrea),
    .fbuf_addr  (fbuf_addr),
    .fbuf_data  (fbuf_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg_at(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push(input logic [AW-1:0] a,
                      input logic [DW-1:0] d,
                      input int c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic drv(input bit ch, input bit v,
                     input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
    if (ch) begin
      c1.valid = v; c1.addr = a; c1.data = d;
    end else begin
      c0.valid = v; c0.addr = a; c0.data = d;
    end
  endtask

  // Presents n consecutive beats, advancing on each accepted beat.
  task automatic stream(input bit ch,
                        input logic [AW-1:0] a0,
                        input logic [DW-1:0] d0,
                        input int n);
    int i = 0;
    int stall = 0;
    bit x;
    drv(ch, 1'b1, a0, d0);
    while (i < n) begin
      @(negedge clk);
      x = ch ? (c1.valid && c1.ready) : (c0.valid && c0.ready);
      tick();
      if (x) begin
        i++;
        stall = 0;
        if (i < n) drv(ch, 1'b1, a0 + AW'(i), d0 + DW'(i));
        else drv(ch, 1'b0, a0 + AW'(i - 1), d0 + DW'(i - 1));
      end else begin
        stall++;
        if (stall > 200) begin
          n_checks++;
          n_fail++;
          $display("FAIL stall ch%0d: beat %0d not accepted in 200 cycles",
                   ch, i);
          drv(ch, 1'b0, a0, d0);
          break;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (fbuf_en_wr) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %h data %h cycle %0d, required none",
                 fbuf_addr, fbuf_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(fbuf_addr), 32'(mon_e.addr));
        chk("wr_data", 32'(fbuf_data), 32'(mon_e.data));
        chk("wr_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("wr_wrea", 32'(fbuf_wrea), 32'd1);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drv(1'b0, 1'b0, '0, '0);
    drv(1'b1, 1'b0, '0, '0);
    repeat (3) tick();
    rst = 1'b0;

    // Idle after reset: nothing granted, no strobes.
    repeat (10) tick();
    @(negedge clk);
    chk("rst_en", 32'(fbuf_en_wr), 32'd0);
    chk("rst_wrea", 32'(fbuf_wrea), 32'd0);
    chk("rst_addr", 32'(fbuf_addr), 32'd0);
    chk("rst_data", 32'(fbuf_data), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy0", 32'(c0.ready), 32'd0);
    chk("rst_rdy1", 32'(c1.ready), 32'd0);

    // ch0 alone, 5 beats.
    tick();
    t0 = cyc;
    for (int k = 0; k < 5; k++)
      push(19'h100 + AW'(k), 8'hA0 + DW'(k), t0 + 2 + k);
    fork
      stream(1'b0, 19'h100, 8'hA0, 5);
      begin
        neg_at(t0);
        chk("t2_rdy0_early", 32'(c0.ready), 32'd0);
        neg_at(t0 + 1);
        chk("t2_rdy0", 32'(c0.ready), 32'd1);
        chk("t2_busy", 32'(busy), 32'd1);
      end
    join
    repeat (4) tick();
    chk("t2_drain", 32'(exp_q.size()), 32'd0);
    chk("t2_sel", 32'(sel), 32'd0);
    chk("t2_idle", 32'(busy), 32'd0);

    // Both valid from reset: ch0 first, ch1 after a one-cycle gap.
    do_reset();
    t0 = cyc;
    for (int k = 0; k < 3; k++)
      push(19'h180 + AW'(k), 8'h50 + DW'(k), t0 + 2 + k);
    for (int k = 0; k < 3; k++)
      push(19'h280 + AW'(k), 8'h60 + DW'(k), t0 + 6 + k);
    fork
      stream(1'b0, 19'h180, 8'h50, 3);
      stream(1'b1, 19'h280, 8'h60, 3);
      begin
        neg_at(t0 + 2);
        chk("t3_sel0", 32'(sel), 32'd0);
        chk("t3_rdy1_wait", 32'(c1.ready), 32'd0);
        neg_at(t0 + 5);
        chk("t3_rdy1", 32'(c1.ready), 32'd1);
        chk("t3_sel1", 32'(sel), 32'd1);
      end
    join
    repeat (4) tick();
    chk("t3_drain", 32'(exp_q.size()), 32'd0);
    chk("t3_sel_hold", 32'(sel), 32'd1);

    // Both streaming 8 beats each.
    do_reset();
    t0 = cyc;
`ifdef FBUF_ARB_BURST_LIMIT_EN
    for (int k = 0; k < 4; k++)
      push(19'h200 + AW'(k), 8'h10 + DW'(k), t0 + 2 + k);
    for (int k = 0; k < 4; k++)
      push(19'h300 + AW'(k), 8'h80 + DW'(k), t0 + 6 + k);
    for (int k = 4; k < 8; k++)
      push(19'h200 + AW'(k), 8'h10 + DW'(k), t0 + 6 + k);
    for (int k = 4; k < 8; k++)
      push(19'h300 + AW'(k), 8'h80 + DW'(k), t0 + 10 + k);
`else
    for (int k = 0; k < 8; k++)
      push(19'h200 + AW'(k), 8'h10 + DW'(k), t0 + 2 + k);
    for (int k = 0; k < 8; k++)
      push(19'h300 + AW'(k), 8'h80 + DW'(k), t0 + 11 + k);
`endif
    fork
      stream(1'b0, 19'h200, 8'h10, 8);
      stream(1'b1, 19'h300, 8'h80, 8);
      begin
        neg_at(t0 + 5);
`ifdef FBUF_ARB_BURST_LIMIT_EN
        chk("t4_rot_rdy1", 32'(c1.ready), 32'd1);
        chk("t4_rot_sel", 32'(sel), 32'd1);
`else
        chk("t4_hold_rdy1", 32'(c1.ready), 32'd0);
        chk("t4_hold_sel", 32'(sel), 32'd0);
`endif
      end
    join
    repeat (4) tick();
    chk("t4_drain", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a ch1 burst.
    do_reset();
    t0 = cyc;
    drv(1'b1, 1'b1, 19'h400, 8'hC0);
    push(19'h400, 8'hC0, t0 + 2);
    push(19'h401, 8'hC1, t0 + 3);
    push(19'h402, 8'hC2, t0 + 4);
    tick();
    tick();
    drv(1'b1, 1'b1, 19'h401, 8'hC1);
    tick();
    drv(1'b1, 1'b1, 19'h402, 8'hC2);
    tick();
    drv(1'b1, 1'b1, 19'h403, 8'hC3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drv(1'b0, 1'b1, 19'h500, 8'hD0);
    push(19'h500, 8'hD0, t0 + 7);
    @(negedge clk);
    chk("t5_en", 32'(fbuf_en_wr), 32'd0);
    chk("t5_wrea", 32'(fbuf_wrea), 32'd0);
    chk("t5_addr", 32'(fbuf_addr), 32'd0);
    chk("t5_data", 32'(fbuf_data), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_rdy1", 32'(c1.ready), 32'd0);
    chk("t5_sel", 32'(sel), 32'd0);
    tick();
    @(negedge clk);
    chk("t5_tie_rdy0", 32'(c0.ready), 32'd1);
    chk("t5_tie_rdy1", 32'(c1.ready), 32'd0);
    tick();
    drv(1'b0, 1'b0, 19'h500, 8'hD0);
    drv(1'b1, 1'b0, 19'h403, 8'hC3);
    repeat (3) tick();
    chk("t5_drain", 32'(exp_q.size()), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
